// File: rtl/fetch_line_buffer_sub_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_line_buffer_sub_unit
// Function : Single-line instruction fetch buffer with critical-word-first
//            return. Macro FETCH_LINE_BUFFER_EN enables the line storage;
//            without it every fetch is a single-beat backend read.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_line_buffer_sub_unit #(
  parameter int LINE_WORDS = 4,
  parameter int MEM_ADDR_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  new_request,
  input  logic [MEM_ADDR_W-1:0] addr,
  input  logic                  re,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [31:0]           data_in,
  output logic                  ready,
  output logic                  data_valid,
  output logic [31:0]           data_out,
  input  logic                  ifence,
  output logic                  mem_request,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  localparam int c_off_w = $clog2(LINE_WORDS);
  localparam logic [c_off_w-1:0] c_last_beat = c_off_w'(LINE_WORDS - 1);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_req  = 2'd1;
  localparam logic [1:0] c_st_fill = 2'd2;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [MEM_ADDR_W-1:0] r_addr;
  logic [c_off_w-1:0]    r_cnt;
  logic                  r_data_valid;
  logic [31:0]           r_data_out;

  logic                  w_hit;
  logic [31:0]           w_hit_word;
  logic                  w_crit;
  logic                  w_last_beat;
  logic                  w_accept;
  logic                  w_beat;
  logic                  w_unused;

  assign w_accept = (r_state == c_st_idle) && new_request;
  assign w_beat   = (r_state == c_st_fill) && mem_rvalid;

`ifdef FETCH_LINE_BUFFER_EN
  localparam int c_tag_lsb = c_off_w + 2;

  logic [31:0]                     r_line [LINE_WORDS];
  logic [MEM_ADDR_W-c_tag_lsb-1:0] r_tag;
  logic                            r_valid;
  logic                            r_fence_pend;

  assign w_hit       = r_valid && (addr[MEM_ADDR_W-1:c_tag_lsb] == r_tag);
  assign w_hit_word  = r_line[addr[c_tag_lsb-1:2]];
  assign w_crit      = (r_cnt == r_addr[c_tag_lsb-1:2]);
  assign w_last_beat = (r_cnt == c_last_beat);
  assign mem_addr    = {r_addr[MEM_ADDR_W-1:c_tag_lsb], {c_tag_lsb{1'b0}}};
  assign w_unused    = ^{re, we, be, data_in, r_addr[1:0]};

  always_ff @(posedge clk) begin
    if (w_beat) r_line[r_cnt] <= mem_rdata;
  end

  // A fence seen while a fill is in flight must leave the refilled line invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= 1'b0;
      r_tag        <= '0;
      r_fence_pend <= 1'b0;
    end else if (w_accept && !w_hit) begin
      r_valid      <= 1'b0;
      r_fence_pend <= 1'b0;
    end else if (w_beat && w_last_beat) begin
      r_valid      <= !(r_fence_pend || ifence);
      r_tag        <= r_addr[MEM_ADDR_W-1:c_tag_lsb];
    end else if (ifence) begin
      r_valid      <= 1'b0;
      r_fence_pend <= (r_state != c_st_idle);
    end
  end
`else
  assign w_hit       = 1'b0;
  assign w_hit_word  = '0;
  assign w_crit      = 1'b1;
  assign w_last_beat = 1'b1;
  assign mem_addr    = {r_addr[MEM_ADDR_W-1:2], 2'b00};
  assign w_unused    = ^{re, we, be, data_in, ifence, r_cnt, c_last_beat, r_addr[1:0]};
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= c_st_idle;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (new_request && !w_hit)     w_next_state = c_st_req;
      c_st_req:  if (mem_ack)                   w_next_state = c_st_fill;
      c_st_fill: if (mem_rvalid && w_last_beat) w_next_state = c_st_idle;
      default:                                  w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    ready       = (r_state == c_st_idle);
    mem_request = (r_state == c_st_req);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_cnt        <= '0;
      r_data_valid <= 1'b0;
      r_data_out   <= '0;
    end else begin
      r_data_valid <= 1'b0;
      case (r_state)
        c_st_idle: begin
          if (new_request) begin
            if (w_hit) begin
              r_data_valid <= 1'b1;
              r_data_out   <= w_hit_word;
            end else begin
              r_addr <= addr;
            end
          end
        end
        c_st_req: begin
          if (mem_ack) r_cnt <= '0;
        end
        c_st_fill: begin
          if (mem_rvalid) begin
            if (w_crit) begin
              r_data_valid <= 1'b1;
              r_data_out   <= mem_rdata;
            end
            if (!w_last_beat) r_cnt <= r_cnt + c_off_w'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign data_valid = r_data_valid;
  assign data_out   = r_data_out;

endmodule
`default_nettype wire

// File: tb/tb_fetch_line_buffer_sub_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_line_buffer_sub_unit
// Function : Self-checking bench for fetch_line_buffer_sub_unit; follows the
//            FETCH_LINE_BUFFER_EN macro to select the expected behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_line_buffer_sub_unit;

  localparam int LINE_WORDS = 4;
  localparam int MEM_ADDR_W = 32;
  localparam int c_off      = $clog2(LINE_WORDS);
  localparam int c_line_b   = LINE_WORDS * 4;
`ifdef FETCH_LINE_BUFFER_EN
  localparam bit c_en = 1'b1;
`else
  localparam bit c_en = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_request = 1'b0;
  logic [31:0] addr = '0;
  logic        re = 1'b1;
  logic        we = 1'b0;
  logic [3:0]  be = 4'hF;
  logic [31:0] data_in = '0;
  logic        ready;
  logic        data_valid;
  logic [31:0] data_out;
  logic        ifence = 1'b0;
  logic        mem_request;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  fetch_line_buffer_sub_unit #(
    .LINE_WORDS(LINE_WORDS),
    .MEM_ADDR_W(MEM_ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .new_request(new_request), .addr(addr),
    .re(re), .we(we), .be(be), .data_in(data_in),
    .ready(ready), .data_valid(data_valid), .data_out(data_out),
    .ifence(ifence), .mem_request(mem_request), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [31:0] data; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int epoch  = 0;

  // Reference view of the buffered line
  bit          m_valid = 1'b0;
  logic [31:0] m_tag   = '0;
  logic [31:0] m_words [LINE_WORDS];
  logic [31:0] lines [4] = '{32'h100, 32'h200, 32'h300, 32'h1000};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Backend memory image; the 0x100 line holds fixed words 0xA0..0xA3
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if ((a >> 4) == 32'h10) return 32'hA0 + ((a >> 2) & 32'h3);
    return (a * 32'h9E3779B1) ^ (32'(epoch) << 20) ^ 32'h0F0F_0000;
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid && ((a >> (c_off + 2)) == m_tag);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      chk("dv_missing_at_cycle", cyc, mon_e.cyc);
    end
    if (data_valid) begin
      if (exp_q.size() == 0) begin
        chk("dv_spurious", data_valid, 1'b0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dv_cycle", cyc, mon_e.cyc);
        chk("dv_data", data_out, mon_e.data);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; new_request = 1'b0; ifence = 1'b0;
    mem_ack = 1'b0; mem_rvalid = 1'b0;
    step();
    step();
    chk("rst_ready", ready, 1'b1);
    chk("rst_data_valid", data_valid, 1'b0);
    chk("rst_data_out", data_out, 32'h0);
    chk("rst_mem_request", mem_request, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      step();
      n++;
    end
    if (!ready) chk("ready_timeout", ready, 1'b1);
  endtask

  task automatic access(input logic [31:0] a, input bit fence_with, input bit fence_in_fill,
                        input int abort_after, input int ack_dly);
    logic [31:0] base;
    logic [31:0] d;
    int          nb;
    int          crit;
    int          n;
    int          dly;
    bit          hit;
    bit          fenced;
    wait_ready();
    hit  = m_hit(a);
    base = c_en ? (a & ~32'(c_line_b - 1)) : (a & ~32'h3);
    nb   = c_en ? LINE_WORDS : 1;
    crit = c_en ? int'((a >> 2) % LINE_WORDS) : 0;
    new_request = 1'b1; addr = a; ifence = fence_with;
    if (hit) exp_q.push_back('{cyc + 1, m_words[(a >> 2) % LINE_WORDS]});
    step();
    new_request = 1'b0; ifence = 1'b0; addr = $urandom();
    if (fence_with) begin
      epoch++;
      m_valid = 1'b0;
    end
    if (hit) return;
    m_valid = 1'b0;
    n = 0;
    while (!mem_request && n < 20) begin
      step();
      n++;
    end
    chk("mem_request", mem_request, 1'b1);
    chk("mem_addr", mem_addr, base);
    chk("ready_low", ready, 1'b0);
    dly = (ack_dly < 0) ? int'($urandom_range(0, 3)) : ack_dly;
    repeat (dly) begin
      mem_rvalid  = ($urandom_range(0, 1) == 1);
      mem_rdata   = $urandom();
      new_request = ($urandom_range(0, 1) == 1);
      step();
      chk("mem_request_held", mem_request, 1'b1);
    end
    mem_rvalid = 1'b0; new_request = 1'b0; mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("mem_request_drop", mem_request, 1'b0);
    fenced = 1'b0;
    for (int i = 0; i < nb; i++) begin
      if (i == abort_after) begin
        do_reset();
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        new_request = ($urandom_range(0, 1) == 1);
        addr = $urandom();
        step();
      end
      new_request = 1'b0;
      if (fence_in_fill && i == nb / 2) begin
        ifence = 1'b1;
        step();
        ifence = 1'b0;
        fenced = 1'b1;
        epoch++;
      end
      d = mem_word(base + 32'(4 * i));
      mem_rvalid = 1'b1; mem_rdata = d; m_words[i] = d;
      if (i == crit) exp_q.push_back('{cyc + 1, d});
      step();
      mem_rvalid = 1'b0; mem_rdata = $urandom();
    end
    chk("ready_after_fill", ready, 1'b1);
    m_valid = c_en && !fenced;
    m_tag   = a >> (c_off + 2);
  endtask

  task automatic hit_burst(input logic [31:0] start, input int n);
    logic [31:0] a;
    wait_ready();
    for (int i = 0; i < n; i++) begin
      a = start + 32'(4 * i);
      new_request = 1'b1; addr = a;
      exp_q.push_back('{cyc + 1, m_words[(a >> 2) % LINE_WORDS]});
      step();
      chk("burst_no_mem_request", mem_request, 1'b0);
      chk("burst_ready", ready, 1'b1);
    end
    new_request = 1'b0;
  endtask

  initial begin
    int          r;
    int          wd;
    logic [31:0] a;
    bit          h;
    do_reset();
    access(32'h100, 1'b0, 1'b0, -1, 2);
`ifdef FETCH_LINE_BUFFER_EN
    hit_burst(32'h104, 3);
`else
    access(32'h104, 1'b0, 1'b0, -1, -1);
    access(32'h108, 1'b0, 1'b0, -1, -1);
    access(32'h10C, 1'b0, 1'b0, -1, -1);
`endif
    access(32'h20C, 1'b0, 1'b0, -1, -1);
    access(32'h100, 1'b0, 1'b1, -1, -1);
    access(32'h104, 1'b0, 1'b0, -1, -1);
    access(32'h30C, 1'b0, 1'b0, c_en ? 2 : 0, -1);
    access(32'h100, 1'b0, 1'b0, -1, -1);

    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (m_valid && r < 2) begin
        wd = $urandom_range(0, LINE_WORDS - 1);
        hit_burst((m_tag << (c_off + 2)) + 32'(wd * 4), LINE_WORDS - wd);
      end else if (r == 2) begin
        wait_ready();
        ifence = 1'b1;
        step();
        ifence = 1'b0;
        epoch++;
        m_valid = 1'b0;
      end else begin
        if (m_valid && r < 6) a = (m_tag << (c_off + 2)) | $urandom_range(0, c_line_b - 1);
        else a = lines[$urandom_range(0, 3)] | $urandom_range(0, c_line_b - 1);
        h = m_hit(a);
        access(a, h && ($urandom_range(0, 3) == 0), !h && ($urandom_range(0, 4) == 0), -1, -1);
      end
    end

    repeat (4) step();
    chk("pending_expectations", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_line_buffer_sub_unit.md
FETCH_LINE_BUFFER_SUB_UNIT -- requirements
Module: fetch_line_buffer_sub_unit

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, words per line; power of two, 2..16.
REQ-002 SHALL have parameter MEM_ADDR_W, default 32, byte-address width of addr and mem_addr.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port new_request  input  1  fetch request strobe, valid only while ready=1.
REQ-006 SHALL have port addr  input  MEM_ADDR_W  request byte address; bits [1:0] are ignored.
REQ-007 SHALL have ports re/we/be/data_in  input  1/1/4/32  sub-unit protocol fields; we, be and data_in are ignored, so every request is a read.
REQ-008 SHALL have port ready  output  1  sub-unit accepts new_request this cycle.
REQ-009 SHALL have port data_valid  output  1  single-cycle strobe qualifying data_out.
REQ-010 SHALL have port data_out  output  32  instruction word.
REQ-011 SHALL have port ifence  input  1  invalidate the line buffer.
REQ-012 SHALL have port mem_request  output  1  backend read request, held until mem_ack.
REQ-013 SHALL have port mem_addr  output  MEM_ADDR_W  line-aligned backend address.
REQ-014 SHALL have port mem_ack  input  1  backend has accepted the request.
REQ-015 SHALL have ports mem_rvalid/mem_rdata  input  1/32  backend read beats, returned in ascending word order.

Function
REQ-016 SHALL hold one line: tag = addr[MEM_ADDR_W-1:log2(LINE_WORDS)+2], a valid bit and LINE_WORDS data words.
REQ-017 SHALL implement the states IDLE, REQ and FILL.
REQ-018 IDLE: ready=1; new_request whose tag matches a valid line (hit) SHALL assert data_valid on the next cycle with the selected word; the FSM SHALL stay in IDLE, so back-to-back hits run at one word per cycle.
REQ-019 IDLE: new_request that misses SHALL latch addr, drop ready on the next cycle and move to REQ.
REQ-020 REQ: mem_request=1 and mem_addr = latched addr with bits [log2(LINE_WORDS)+1:0] zeroed; on mem_ack the FSM SHALL move to FILL and clear the beat counter.
REQ-021 FILL: each mem_rvalid SHALL write mem_rdata to word[counter], then increment the counter (log2(LINE_WORDS) bits, no wrap beyond the final beat).
REQ-022 The cycle after the beat whose index equals the requested word index (critical word), data_valid SHALL be 1 and data_out SHALL equal that beat's data.
REQ-023 After beat LINE_WORDS-1 the line SHALL be marked valid with the latched tag and the FSM SHALL return to IDLE; ready SHALL be 1 on the following cycle.
REQ-024 Exactly one data_valid SHALL be produced per accepted new_request; data_valid SHALL never be asserted without a pending request.
REQ-025 ifence SHALL clear the valid bit the next cycle; an ifence during REQ/FILL SHALL let the fill and its response complete, but the line SHALL end invalid.
REQ-026 An ifence coincident with a hit SHALL still return the hit data, and the line SHALL become invalid afterwards.
REQ-027 new_request while ready=0 is a protocol violation and SHALL be ignored.
REQ-028 mem_rvalid outside FILL SHALL be ignored.

Reset
REQ-029 On rst: FSM=IDLE, ready=1, data_valid=0, data_out=0, mem_request=0, mem_addr=0, line valid=0, counter=0.
REQ-030 rst mid-fill SHALL abandon the fill and drop any pending response; the backend is reset together with this block.

Configuration
REQ-031 Macro FETCH_LINE_BUFFER_EN defined: line buffer behaviour as in REQ-016..REQ-026.
REQ-032 Macro FETCH_LINE_BUFFER_EN undefined: no line storage and every request misses; mem_addr = addr with bits [1:0] zeroed; a single beat is expected; data_valid follows the cycle after that beat; ifence has no effect; port list is unchanged.

Verification
REQ-033 Reset, then new_request addr=0x100; ack after 2 cycles; beats 0xA0..0xA3 -> mem_addr=0x100, data_valid one cycle after the first beat with data_out=0xA0, ready=1 after the fourth beat.
REQ-034 After REQ-033, requests 0x104, 0x108, 0x10C on consecutive cycles -> data_valid on 3 consecutive cycles with 0xA1, 0xA2, 0xA3, and mem_request stays 0.
REQ-035 Miss at addr=0x20C -> mem_addr=0x200, data_valid only after the 4th beat, data_out = 4th beat.
REQ-036 ifence asserted during FILL, then request 0x104 -> the fill response still returned; the 0x104 request misses and mem_request=1.
REQ-037 rst asserted after the 2nd beat, then request 0x100 -> no data_valid for the aborted request; new fill issued at 0x100.
REQ-038 FETCH_LINE_BUFFER_EN undefined: requests 0x100 then 0x104 -> two backend requests at 0x100 and 0x104, one beat each.
